// File: rtl/imem_load_responder.sv
`timescale 1ns/1ps
// imem_load_responder
//
// Instruction-memory responder for the fetch stage, with a byte-stream program loader.
// The fetch read is combinational. The array serves reads only once a load has
// completed (state DONE). In every other state, and for out-of-range addresses, the
// read returns NOP_WORD. The core is held (cpu_hold=1) whenever the block is not in DONE.
//
// Optional feature: define IMEM_CHECKSUM_EN to add a CHECK state. In that state one
// trailing checksum byte must make the 8-bit sum of all program bytes wrap to zero.
//
// Ports:
//   clk, reset    clock; asynchronous active-high reset
//   address       fetch byte address (word index = address[IDX_W+1:2])
//   data          instruction word, or NOP_WORD when not served
//   addr_fault    address lies beyond the array
//   cpu_hold      stall request to the core
//   load_start    pulse that (re)starts a load; samples load_words
//   load_words    number of words in the program
//   load_valid    load_byte is valid
//   load_byte     program byte, little-endian within a word
//   load_ready    a byte is accepted this cycle if load_valid is also high
//   load_done     one-cycle pulse in the first DONE cycle
//   load_error    sticky error, cleared by load_start
//   words_loaded  words written by the current/last load
module imem_load_responder #(
    parameter int unsigned  DEPTH_WORDS = 1024,
    parameter logic [31:0]  NOP_WORD    = 32'h00000013,
    localparam int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      address,
    output logic [31:0]      data,
    output logic             addr_fault,
    output logic             cpu_hold,
    input  logic             load_start,
    input  logic [IDX_W:0]   load_words,
    input  logic             load_valid,
    input  logic [7:0]       load_byte,
    output logic             load_ready,
    output logic             load_done,
    output logic             load_error,
    output logic [IDX_W:0]   words_loaded
);

`ifdef IMEM_CHECKSUM_EN
    typedef enum logic [1:0] {StIdle, StLoad, StCheck, StDone} state_e;
    localparam state_e StLoadExit = StCheck;
`else
    typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;
    localparam state_e StLoadExit = StDone;
`endif

    localparam logic [IDX_W:0] DepthCount = (IDX_W + 1)'(DEPTH_WORDS);

    state_e           state_q, state_d;
    logic [1:0]       lane_q, lane_d;
    // Bytes for lanes 0..2; lane 3 comes straight from load_byte on the write edge.
    logic [23:0]      asm_q, asm_d;
    logic [IDX_W:0]   count_q, count_d;
    logic [IDX_W:0]   target_q, target_d;
    logic             error_q, error_d;
    logic             done_q, done_d;

    logic [31:0]      mem [DEPTH_WORDS];

    logic             start_bad;
    logic             load_empty;
    logic             accept;
    logic             word_write;
    logic             last_word;
    logic [IDX_W-1:0] word_idx;
    logic             unused_addr_bits;

`ifdef IMEM_CHECKSUM_EN
    logic [7:0]       sum_q, sum_d;
    logic [7:0]       sum_next;
    logic             sum_ok;

    assign sum_next = sum_q + load_byte;
    assign sum_ok   = (sum_next == 8'd0);
`endif

    assign start_bad  = load_words > DepthCount;
    // Only true in LOAD for a zero-word load; a nonzero load leaves LOAD on its last write.
    assign load_empty = (count_q == target_q);
    assign accept     = load_valid && load_ready;
    assign word_write = (state_q == StLoad) && accept && (lane_q == 2'd3) && !load_start;
    assign last_word  = ((count_q + 1'b1) == target_q);

    // ---------------------------------------------------------------- FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------- FSM next state
    always_comb begin
        state_d = state_q;
        if (load_start) begin
            state_d = start_bad ? StIdle : StLoad;
        end else begin
            unique case (state_q)
                StLoad: begin
                    if (load_empty || (word_write && last_word)) begin
                        state_d = StLoadExit;
                    end
                end
`ifdef IMEM_CHECKSUM_EN
                StCheck: begin
                    if (accept) begin
                        state_d = sum_ok ? StDone : StIdle;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    // ---------------------------------------------------------------- FSM outputs
    always_comb begin
        cpu_hold   = 1'b1;
        load_ready = 1'b0;
        unique case (state_q)
            StLoad:  load_ready = !load_empty;
`ifdef IMEM_CHECKSUM_EN
            StCheck: load_ready = 1'b1;
`endif
            StDone:  cpu_hold = 1'b0;
            default: ;
        endcase
    end

    // ---------------------------------------------------------------- loader datapath
    always_comb begin
        lane_d   = lane_q;
        asm_d    = asm_q;
        count_d  = count_q;
        target_d = target_q;
        error_d  = error_q;
`ifdef IMEM_CHECKSUM_EN
        sum_d    = sum_q;
`endif
        // The pulse fires on entry to DONE; load_start never targets DONE.
        done_d   = (state_d == StDone) && (state_q != StDone);

        if (load_start) begin
            target_d = load_words;
            count_d  = '0;
            lane_d   = '0;
            asm_d    = '0;
            error_d  = start_bad;
`ifdef IMEM_CHECKSUM_EN
            sum_d    = '0;
`endif
        end else if ((state_q == StLoad) && accept) begin
`ifdef IMEM_CHECKSUM_EN
            sum_d = sum_next;
`endif
            unique case (lane_q)
                2'd0: asm_d[7:0]   = load_byte;
                2'd1: asm_d[15:8]  = load_byte;
                2'd2: asm_d[23:16] = load_byte;
                default: begin
                    asm_d   = '0;
                    count_d = count_q + 1'b1;
                end
            endcase
            lane_d = lane_q + 2'd1;
`ifdef IMEM_CHECKSUM_EN
        end else if ((state_q == StCheck) && accept) begin
            if (!sum_ok) begin
                error_d = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lane_q   <= '0;
            asm_q    <= '0;
            count_q  <= '0;
            target_q <= '0;
            error_q  <= 1'b0;
            done_q   <= 1'b0;
`ifdef IMEM_CHECKSUM_EN
            sum_q    <= '0;
`endif
        end else begin
            lane_q   <= lane_d;
            asm_q    <= asm_d;
            count_q  <= count_d;
            target_q <= target_d;
            error_q  <= error_d;
            done_q   <= done_d;
`ifdef IMEM_CHECKSUM_EN
            sum_q    <= sum_d;
`endif
        end
    end

    // Array is deliberately not reset; a reset mid-load keeps words already written.
    always_ff @(posedge clk) begin
        if (word_write) begin
            mem[count_q[IDX_W-1:0]] <= {load_byte, asm_q};
        end
    end

    // ---------------------------------------------------------------- fetch read
    // Byte offset is ignored; the fetch stage picks the halfword it needs.
    assign unused_addr_bits = ^address[1:0];
    assign word_idx         = address[IDX_W+1:2];
    assign addr_fault       = |address[31:IDX_W+2];
    assign data             = ((state_q == StDone) && !addr_fault) ? mem[word_idx] : NOP_WORD;

    assign load_done    = done_q;
    assign load_error   = error_q;
    assign words_loaded = count_q;

endmodule

// File: tb/tb_imem_load_responder.sv
`timescale 1ns/1ps
module tb_imem_load_responder;

    localparam int          DEPTH = 1024;
    localparam int          IW    = 10;
    localparam logic [31:0] NOP   = 32'h00000013;
`ifdef IMEM_CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    localparam int M_IDLE  = 0;
    localparam int M_LOAD  = 1;
    localparam int M_CHECK = 2;
    localparam int M_DONE  = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [31:0]   address = '0;
    logic [31:0]   data;
    logic          addr_fault;
    logic          cpu_hold;
    logic          load_start = 1'b0;
    logic [IW:0]   load_words = '0;
    logic          load_valid = 1'b0;
    logic [7:0]    load_byte = '0;
    logic          load_ready;
    logic          load_done;
    logic          load_error;
    logic [IW:0]   words_loaded;

    int checks = 0;
    int failures = 0;
    int done_seen = 0;

    imem_load_responder dut (
        .clk          (clk),
        .reset        (reset),
        .address      (address),
        .data         (data),
        .addr_fault   (addr_fault),
        .cpu_hold     (cpu_hold),
        .load_start   (load_start),
        .load_words   (load_words),
        .load_valid   (load_valid),
        .load_byte    (load_byte),
        .load_ready   (load_ready),
        .load_done    (load_done),
        .load_error   (load_error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------ behavioural model
    int          m_mode = M_IDLE;
    int          m_target = 0;
    int          m_cnt = 0;
    int          m_nb = 0;
    logic [31:0] m_part = '0;
    logic [7:0]  m_sum = '0;
    bit          m_err = 1'b0;
    bit          m_done = 1'b0;
    logic [31:0] m_mem [DEPTH];
    bit          m_known [DEPTH];

    task automatic model_finish_words();
        if (CSUM) m_mode = M_CHECK;
        else begin
            m_mode = M_DONE;
            m_done = 1'b1;
        end
    endtask

    task automatic model_step();
        m_done = 1'b0;
        if (reset) begin
            m_mode = M_IDLE; m_cnt = 0; m_nb = 0; m_part = '0; m_err = 1'b0; m_sum = '0;
        end else if (load_start) begin
            m_target = int'(load_words);
            m_cnt = 0; m_nb = 0; m_part = '0; m_sum = '0;
            m_err = (m_target > DEPTH);
            m_mode = m_err ? M_IDLE : M_LOAD;
        end else if (m_mode == M_LOAD) begin
            if (m_cnt == m_target) begin
                model_finish_words();
            end else if (load_valid) begin
                m_part[8*m_nb +: 8] = load_byte;
                m_sum = m_sum + load_byte;
                m_nb++;
                if (m_nb == 4) begin
                    m_mem[m_cnt] = m_part;
                    m_known[m_cnt] = 1'b1;
                    m_cnt++;
                    m_nb = 0;
                    m_part = '0;
                    if (m_cnt == m_target) model_finish_words();
                end
            end
        end else if (m_mode == M_CHECK && load_valid) begin
            if (8'(m_sum + load_byte) == 8'd0) begin
                m_mode = M_DONE;
                m_done = 1'b1;
            end else begin
                m_mode = M_IDLE;
                m_err = 1'b1;
            end
        end
    endtask

    always @(posedge clk) model_step();

    // ------------------------------------------------------------ per-cycle compare
    always @(negedge clk) begin
        bit fault;
        if (!reset) begin
            if (load_done) done_seen++;
            fault = (address >= 32'(4 * DEPTH));
            check("cpu_hold", cpu_hold, m_mode != M_DONE);
            check("load_ready", load_ready,
                  (m_mode == M_LOAD && m_cnt != m_target) || m_mode == M_CHECK);
            check("load_done", load_done, m_done);
            check("load_error", load_error, m_err);
            check("words_loaded", words_loaded, 32'(m_cnt));
            check("addr_fault", addr_fault, fault);
            if (m_mode == M_DONE && !fault) begin
                if (m_known[address[11:2]]) check("data", data, m_mem[address[11:2]]);
            end else begin
                check("data_nop", data, NOP);
            end
        end
    end

    // ------------------------------------------------------------ stimulus helpers
    logic [31:0] prog [8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 3) == 0) return $urandom;
        return $urandom_range(0, 31);
    endfunction

    task automatic idle_random(input int n);
        repeat (n) begin
            address = rand_addr();
            tick();
        end
    endtask

    task automatic start_load(input int n);
        load_words = (IW + 1)'(n);
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        load_valid = 1'b0;
        repeat (gap) tick();
        load_byte = b;
        load_valid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!load_ready && t < 50) begin
            t++;
            @(negedge clk);
        end
        if (!load_ready) begin
            checks++;
            failures++;
            $display("FAIL send_byte: load_ready stayed 0 for byte 0x%02h, required 1", b);
        end
        tick();
        load_valid = 1'b0;
    endtask

    // Sends prog[0..n-1] (plus a correct checksum byte when enabled).
    task automatic load_prog(input int n, input int gap);
        logic [7:0] sum;
        sum = '0;
        start_load(n);
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 4; k++) begin
                sum = sum + prog[i][8*k +: 8];
                send_byte(prog[i][8*k +: 8], gap);
            end
        end
        if (CSUM) send_byte(-sum, gap);
        idle(3);
    endtask

    task automatic read_check(input string name, input logic [31:0] a, input logic [31:0] exp);
        address = a;
        @(negedge clk);
        check(name, data, exp);
        tick();
    endtask

    // ------------------------------------------------------------ main sequence
    initial begin
        int d0;
        int n;
        int nb;
        bit abort;
        logic [7:0] b;
        logic [7:0] sum;

        for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;

        idle(3);
        reset = 1'b0;

        // Reset state
        @(negedge clk);
        check("t1 data", data, 32'h00000013);
        check("t1 cpu_hold", cpu_hold, 1);
        check("t1 load_ready", load_ready, 0);
        check("t1 addr_fault", addr_fault, 0);
        check("t1 words_loaded", words_loaded, 0);
        tick();

        // Two-word load, back-to-back bytes
        prog[0] = 32'h00500513;
        prog[1] = 32'h00100593;
        d0 = done_seen;
        load_prog(2, 0);
        check("t2 done_pulses", done_seen - d0, 1);
        check("t2 words_loaded", words_loaded, 2);
        check("t2 cpu_hold", cpu_hold, 0);
        read_check("t2 addr0", 32'd0, 32'h00500513);
        read_check("t2 addr4", 32'd4, 32'h00100593);
        read_check("t2 addr6", 32'd6, 32'h00100593);

        // Same stream, load_valid every other cycle
        d0 = done_seen;
        load_prog(2, 1);
        check("t3 done_pulses", done_seen - d0, 1);
        read_check("t3 addr0", 32'd0, 32'h00500513);
        read_check("t3 addr4", 32'd4, 32'h00100593);

        // Restart mid-load
        start_load(3);
        send_byte(8'hAA, 0); send_byte(8'hBB, 0); send_byte(8'hCC, 0);
        send_byte(8'hDD, 0); send_byte(8'hEE, 0);
        prog[0] = 32'h00000013;
        d0 = done_seen;
        load_prog(1, 0);
        check("t4 done_pulses", done_seen - d0, 1);
        check("t4 words_loaded", words_loaded, 1);
        read_check("t4 addr0", 32'd0, 32'h00000013);
        read_check("t4 addr4_kept", 32'd4, 32'h00100593);

        // Oversized load, then a valid one and an out-of-range fetch
        start_load(1025);
        @(negedge clk);
        check("t5 load_error", load_error, 1);
        check("t5 cpu_hold", cpu_hold, 1);
        check("t5 load_ready", load_ready, 0);
        tick();
        prog[0] = 32'h00500513;
        load_prog(1, 0);
        check("t5 error_cleared", load_error, 0);
        address = 32'h00001000;
        @(negedge clk);
        check("t5 fault", addr_fault, 1);
        check("t5 fault_data", data, NOP);
        tick();
        read_check("t5 addr0", 32'd0, 32'h00500513);

        // Zero-word load
        d0 = done_seen;
        load_prog(0, 0);
        check("zero done_pulses", done_seen - d0, 1);
        check("zero words_loaded", words_loaded, 0);

`ifdef IMEM_CHECKSUM_EN
        start_load(1);
        send_byte(8'h13, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
        d0 = done_seen;
        send_byte(8'hED, 0);
        idle(2);
        check("t6 good_done", done_seen - d0, 1);
        check("t6 good_error", load_error, 0);
        start_load(1);
        send_byte(8'h13, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
        send_byte(8'hEE, 0);
        idle(2);
        check("t6 bad_error", load_error, 1);
        check("t6 bad_hold", cpu_hold, 1);
`endif

        // Reset mid-load
        start_load(3);
        for (int j = 0; j < 6; j++) send_byte(8'(j + 1), 0);
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        @(negedge clk);
        check("rst words_loaded", words_loaded, 0);
        check("rst cpu_hold", cpu_hold, 1);
        tick();

        // Randomized loads, restarts, bad sizes, and fetches
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 9) == 0) begin
                start_load(int'($urandom_range(1025, 2047)));
                idle_random(3);
                continue;
            end
            n = int'($urandom_range(0, 5));
            for (int i = 0; i < n; i++) prog[i] = $urandom;
            abort = ($urandom_range(0, 5) == 0);
            nb = abort ? int'($urandom_range(0, 4 * n)) : 4 * n;
            start_load(n);
            sum = '0;
            for (int j = 0; j < nb; j++) begin
                b = prog[j / 4][8 * (j % 4) +: 8];
                sum = sum + b;
                address = rand_addr();
                send_byte(b, int'($urandom_range(0, 2)));
            end
            if (!abort) begin
                if (CSUM) begin
                    b = -sum;
                    if ($urandom_range(0, 3) == 0) b = b + 8'd1;
                    send_byte(b, 0);
                end
                idle_random(6);
            end
        end

        idle(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
